// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a valid/ready handshake.
// The rotating priority pointer moves to the index just past the granted
// requester only when that grant is accepted.
module rr_onehot_arbiter #(
  parameter  int WIDTH = 4,
  localparam int PTR_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [WIDTH-1:0] gnt_onehot,
  output logic [PTR_W-1:0] ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   ptr_inc;
  logic [PTR_W-1:0]   scan_base;
  logic [WIDTH-1:0]   pick_onehot;
  logic               handshake;

  // Every output comes straight from a flop, so req and gnt_ready never reach a port combinationally.
  assign gnt_valid  = (state_q == GRANT);
  assign gnt_onehot = gnt_q;
  assign ptr        = ptr_q;

  assign handshake  = (state_q == GRANT) && gnt_ready;

  // Encode the currently held one-hot grant and compute the pointer that follows it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt_q[i]) gnt_idx = PTR_W'(i);
    end
    ptr_inc = (gnt_idx == PTR_W'(WIDTH - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  // Scan req cyclically upward from the priority base; the base is the advanced pointer on a handshake.
  always_comb begin
    int   idx;
    logic found;
    scan_base   = handshake ? ptr_inc : ptr_q;
    pick_onehot = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = int'(scan_base) + i;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!found && req[PTR_W'(idx)]) begin
        pick_onehot[PTR_W'(idx)] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

  // Next-state logic: hold while a grant waits, advance on a handshake, start from IDLE when anyone asks.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          ptr_d = ptr_inc;
          if (|req) begin
            gnt_d = pick_onehot;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset that discards any pending grant.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter (WIDTH=4): directed vector table,
// a starvation-bound sequence, and randomized traffic against a reference model.
module tb_rr_onehot_arbiter;

  localparam int W = 4;
  localparam int PW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req;
  logic          gnt_ready;
  logic          gnt_valid;
  logic [W-1:0]  gnt_onehot;
  logic [PW-1:0] ptr;

  int checks = 0;
  int errors = 0;

  rr_onehot_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .ptr        (ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] req;
    logic         rdy;
    logic         exp_valid;
    logic [W-1:0] exp_gnt;
    int           exp_ptr;
  } vec_t;

  // Reference model: grant as an index plus a flag, pointer as a plain integer.
  bit m_valid;
  int m_idx;
  int m_ptr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int first_from(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      if (r[(p + k) % W]) return (p + k) % W;
    end
    return -1;
  endfunction

  // Advance the model by one edge using the inputs present now, then step the DUT.
  task automatic cycle();
    bit n_valid;
    int n_idx;
    int n_ptr;
    n_valid = m_valid;
    n_idx   = m_idx;
    n_ptr   = m_ptr;
    if (rst) begin
      n_valid = 0;
      n_ptr   = 0;
    end else if (!m_valid) begin
      if (req != 0) begin
        n_valid = 1;
        n_idx   = first_from(req, m_ptr);
      end
    end else if (gnt_ready) begin
      n_ptr = (m_idx + 1) % W;
      if (req != 0) n_idx = first_from(req, n_ptr);
      else          n_valid = 0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid;
    m_idx   = n_idx;
    m_ptr   = n_ptr;
  endtask

  task automatic compare_model(input string tag);
    logic [W-1:0] exp_gnt;
    exp_gnt = m_valid ? W'(1 << m_idx) : '0;
    check({tag, "_valid"}, int'(gnt_valid), int'(m_valid));
    check({tag, "_gnt"},   int'(gnt_onehot), int'(exp_gnt));
    check({tag, "_ptr"},   int'(ptr), m_ptr);
    check({tag, "_onehot"}, ($countones(gnt_onehot) == (gnt_valid ? 1 : 0)) ? 1 : 0, 1);
  endtask

  vec_t vecs[$];

  task automatic add(input logic r, input logic [W-1:0] q, input logic y,
                     input logic ev, input logic [W-1:0] eg, input int ep);
    vec_t v;
    v.rst = r; v.req = q; v.rdy = y;
    v.exp_valid = ev; v.exp_gnt = eg; v.exp_ptr = ep;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; req = '0; gnt_ready = 1'b0;
    m_valid = 0; m_idx = 0; m_ptr = 0;

    // Reset, then an idle stretch with gnt_ready toggling (ignored in IDLE).
    add(1, 4'b1111, 1, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 1'(i & 1), 0, 4'b0000, 0);
    // Alternating pair: grants 0010, 1000, 0010; pointer lands on 2, 0, 2 after each acceptance.
    add(0, 4'b1010, 1, 1, 4'b0010, 0);
    add(0, 4'b1010, 1, 1, 4'b1000, 2);
    add(0, 4'b1010, 1, 1, 4'b0010, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 2);
    // Everyone requesting: strict rotation with no bubbles.
    add(1, 4'b1111, 1, 0, 4'b0000, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, 0);
    add(0, 4'b1111, 1, 1, 4'b0010, 1);
    add(0, 4'b1111, 1, 1, 4'b0100, 2);
    add(0, 4'b1111, 1, 1, 4'b1000, 3);
    add(0, 4'b1111, 1, 1, 4'b0001, 0);
    add(0, 4'b1111, 1, 1, 4'b0010, 1);
    add(0, 4'b1111, 1, 1, 4'b0100, 2);
    // Stalled grant 0100 holds while req changes and the granted bit drops.
    add(0, 4'b1111, 0, 1, 4'b0100, 2);
    add(0, 4'b0001, 0, 1, 4'b0100, 2);
    add(0, 4'b0000, 0, 1, 4'b0100, 2);
    add(0, 4'b0001, 1, 1, 4'b0001, 3);
    // Grant 1000 accepted with req empty: pointer wraps to 0, back to idle.
    add(0, 4'b1000, 1, 1, 4'b1000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);
    // Reset during a stalled grant, then restart from pointer 0.
    add(0, 4'b0010, 0, 1, 4'b0010, 0);
    add(0, 4'b0010, 0, 1, 4'b0010, 0);
    add(1, 4'b0011, 0, 0, 4'b0000, 0);
    add(0, 4'b0011, 0, 1, 4'b0001, 0);
    // Reset overrides a simultaneous handshake and clears a nonzero pointer.
    add(0, 4'b0011, 1, 1, 4'b0010, 1);
    add(1, 4'b0011, 1, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; gnt_ready = vecs[i].rdy;
      cycle();
      check($sformatf("vec%0d_valid", i), int'(gnt_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_gnt", i),   int'(gnt_onehot), int'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_ptr", i),   int'(ptr), vecs[i].exp_ptr);
    end

    // Starvation bound: requester 3 holds req among random competitors and must win within W+1 edges.
    for (int t = 0; t < 8; t++) begin
      bit got;
      rst = 1'b1; req = '0; gnt_ready = 1'b1;
      cycle();
      rst = 1'b0;
      got = 0;
      for (int c = 0; c < W + 1 && !got; c++) begin
        req = W'($urandom) | 4'b1000;
        cycle();
        if (gnt_valid && gnt_onehot[3]) got = 1;
      end
      check($sformatf("starve_bound_%0d", t), int'(got), 1);
    end

    // Randomized traffic against the model, with occasional resets.
    rst = 1'b1; req = '0; gnt_ready = 1'b0;
    cycle();
    compare_model("rand_reset");
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      req       = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      gnt_ready = ($urandom_range(0, 3) != 0);
      cycle();
      compare_model($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
